lsu_mem_stage: RTL and testbench

- Load/store unit sitting directly downstream of the instruction decoder. It consumes the decoder's memory controls (mem_read, mem_read_sext, s, iobytes) plus the ALU-computed effective address and the rs2 store data.
- It drives a word-addressed data-memory port with a req/gnt/rvalid handshake.
- It returns an aligned, sign- or zero-extended load result, or completes a store with byte-lane write enables.
- The core stalls while busy is high.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_load_align.sv | 33 +++
 rtl/lsu_mem_stage.sv | 173 +++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and helpers for the load/store unit memory stage.
//   lsu_state_e    : memory-stage FSM states
//   SZ_B/SZ_H/SZ_W : decoder access-size encodings (iobytes)
//   is_misaligned  : natural-alignment check for half and word accesses
//   lane_enables   : byte-lane write enables for a store
//   store_lanes    : store data replicated across the bus word by size
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] SZ_B = 4'b0001;
  localparam logic [3:0] SZ_H = 4'b0011;
  localparam logic [3:0] SZ_W = 4'b1111;

  function automatic logic is_misaligned(input logic [3:0] size, input logic [1:0] offset);
    return ((size == SZ_H) && offset[0]) || ((size == SZ_W) && (offset != 2'b00));
  endfunction

  // Aligned accesses never shift the mask past bit 3, so truncation is safe.
  function automatic logic [3:0] lane_enables(input logic [3:0] size, input logic [1:0] offset);
    return size << offset;
  endfunction

  // Replicating the data lets the memory pick whichever lane the strobes select.
  function automatic logic [31:0] store_lanes(input logic [3:0] size, input logic [31:0] data);
    case (size)
      SZ_B:    return {4{data[7:0]}};
      SZ_H:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data alignment: shifts the addressed bytes of a memory
// word down to bit 0, then sign- or zero-extends to 32 bits.
//   i_rdata  : raw 32-bit memory word
//   i_offset : byte offset of the access within the word
//   i_size   : access size (SZ_B, SZ_H, SZ_W)
//   i_sext   : 1 = sign-extend, 0 = zero-extend
//   o_result : aligned, extended load value
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_offset,
  input  logic [3:0]  i_size,
  input  logic        i_sext,
  output logic [31:0] o_result
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};

  always_comb begin
    case (i_size)
      SZ_B:    o_result = {{24{i_sext & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    o_result = {{16{i_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: o_result = w_shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store memory stage. Takes decoded memory controls plus the effective
// address and store data, runs one access on a req/gnt/rvalid data-memory
// port, and returns an aligned load result or completes a store.
//   clk, reset        : clock, asynchronous active-high reset
//   start             : one-cycle pulse, sample the decoded memory op
//   mem_read/_sext, s : load, load sign-extension, store request
//   iobytes           : access size (0001 byte, 0011 half, 1111 word)
//   addr, wdata_in    : effective byte address, store data
//   busy, done        : stall request, one-cycle completion pulse
//   rdata_out         : load result (valid with done for a load)
//   misaligned        : done-qualified, access skipped for misalignment
//   bus_err           : done-qualified, memory did not respond in MAX_WAIT
//   dmem_*            : word-addressed data memory port
// -----------------------------------------------------------------------------
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_read_sext,
  input  logic        s,
  input  logic [3:0]  iobytes,
  input  logic [31:0] addr,
  input  logic [31:0] wdata_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata_out,
  output logic        misaligned,
  output logic        bus_err,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

  lsu_state_e  r_state;
  logic        r_isStore;
  logic        r_sext;
  logic [3:0]  r_size;
  logic [1:0]  r_offset;
  logic [7:0]  r_cnt;

  logic [7:0]  w_cntNext;
  logic        w_timeout;
  logic [31:0] w_loadResult;

  // The timeout fires when the cycle now ending is the MAX_WAIT-th one spent
  // waiting; a gnt/rvalid in that same cycle still takes priority.
  assign w_cntNext = r_cnt + 8'd1;
  assign w_timeout = (w_cntNext == LP_MAX_WAIT);

  lsu_load_align u_align (
    .i_rdata  (dmem_rdata),
    .i_offset (r_offset),
    .i_size   (r_size),
    .i_sext   (r_sext),
    .o_result (w_loadResult)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_isStore  <= 1'b0;
      r_sext     <= 1'b0;
      r_size     <= 4'd0;
      r_offset   <= 2'd0;
      r_cnt      <= 8'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;
      rdata_out  <= 32'd0;
      dmem_req   <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_we    <= 4'd0;
      dmem_wdata <= 32'd0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      bus_err    <= 1'b0;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_isStore <= s;
            r_sext    <= mem_read_sext;
            r_size    <= iobytes;
            r_offset  <= addr[1:0];
            if (!s && !mem_read) begin
              r_state <= DONE;
              done    <= 1'b1;
            end else if (is_misaligned(iobytes, addr[1:0])) begin
              r_state    <= DONE;
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              r_state   <= REQ;
              r_cnt     <= 8'd0;
              busy      <= 1'b1;
              dmem_req  <= 1'b1;
              dmem_addr <= {addr[31:2], 2'b00};
              // Store wins when both s and mem_read are set.
              if (s) begin
                dmem_we    <= lane_enables(iobytes, addr[1:0]);
                dmem_wdata <= store_lanes(iobytes, wdata_in);
              end else begin
                dmem_we <= 4'd0;
              end
            end
          end
        end

        REQ: begin
          r_cnt <= w_cntNext;
          if (dmem_gnt) begin
            dmem_req <= 1'b0;
            dmem_we  <= 4'd0;
            if (r_isStore) begin
              r_state <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end else if (w_timeout) begin
            r_state  <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bus_err  <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 4'd0;
          end
        end

        // rvalid is only honoured here, so data arriving with gnt is dropped.
        WAIT: begin
          r_cnt <= w_cntNext;
          if (dmem_rvalid) begin
            r_state   <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            rdata_out <= w_loadResult;
          end else if (w_timeout) begin
            r_state <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            bus_err <= 1'b1;
          end
        end

        DONE: begin
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
// Directed bench for lsu_mem_stage: a table of single-access vectors against a
// zero-wait memory, then hand-written wait-state, timeout and reset sequences.
// A second instance with MAX_WAIT=4 covers the timeout boundary.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, startTo;
  logic        memRead, memReadSext, sIn;
  logic [3:0]  iobytes;
  logic [31:0] addr, wdataIn;
  logic        dmemGnt, dmemRvalid;
  logic [31:0] dmemRdata;

  logic        mBusy, mDone, mMis, mErr, mReq;
  logic [31:0] mRdata, mAddr, mWdata;
  logic [3:0]  mWe;
  logic        tBusy, tDone, tMis, tErr, tReq;
  logic [31:0] tRdata, tAddr, tWdata;
  logic [3:0]  tWe;

  logic        sel;
  logic        oBusy, oDone, oMis, oErr, oReq;
  logic [31:0] oRdata, oAddr, oWdata;
  logic [3:0]  oWe;

  int total = 0;
  int bad   = 0;

  int          doneCount, doneCycle, reqCount, busyCycles, reqAfterDone;
  logic        stable, doneMis, doneErr, doneBusy, doneReq;
  logic [31:0] firstAddr, firstWdata, doneRdata;
  logic [3:0]  firstWe;

  typedef struct {
    logic        st;
    logic        ld;
    logic        sx;
    logic [3:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        expAccess;
    logic [31:0] expAddr;
    logic [3:0]  expWe;
    logic [31:0] expWdata;
    logic [31:0] expRdata;
    logic        expMis;
    int          expDone;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  lsu_mem_stage #(.MAX_WAIT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .mem_read(memRead),
    .mem_read_sext(memReadSext), .s(sIn), .iobytes(iobytes), .addr(addr),
    .wdata_in(wdataIn), .busy(mBusy), .done(mDone), .rdata_out(mRdata),
    .misaligned(mMis), .bus_err(mErr), .dmem_req(mReq), .dmem_addr(mAddr),
    .dmem_we(mWe), .dmem_wdata(mWdata), .dmem_gnt(dmemGnt),
    .dmem_rvalid(dmemRvalid), .dmem_rdata(dmemRdata)
  );

  lsu_mem_stage #(.MAX_WAIT(4)) dutTo (
    .clk(clk), .reset(reset), .start(startTo), .mem_read(memRead),
    .mem_read_sext(memReadSext), .s(sIn), .iobytes(iobytes), .addr(addr),
    .wdata_in(wdataIn), .busy(tBusy), .done(tDone), .rdata_out(tRdata),
    .misaligned(tMis), .bus_err(tErr), .dmem_req(tReq), .dmem_addr(tAddr),
    .dmem_we(tWe), .dmem_wdata(tWdata), .dmem_gnt(dmemGnt),
    .dmem_rvalid(dmemRvalid), .dmem_rdata(dmemRdata)
  );

  // Observe whichever instance the current sequence is driving.
  assign oBusy  = sel ? tBusy  : mBusy;
  assign oDone  = sel ? tDone  : mDone;
  assign oMis   = sel ? tMis   : mMis;
  assign oErr   = sel ? tErr   : mErr;
  assign oReq   = sel ? tReq   : mReq;
  assign oRdata = sel ? tRdata : mRdata;
  assign oAddr  = sel ? tAddr  : mAddr;
  assign oWdata = sel ? tWdata : mWdata;
  assign oWe    = sel ? tWe    : mWe;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Starts one access in cycle 0 (called at a negedge), then for cycles
  // 1..nCycles samples outputs at the negedge and drives gnt/rvalid for the
  // rest of that cycle. rvalid is also pulsed with junk data at rvEarly.
  task automatic applyStimulus(input logic useTo, input logic st, input logic ld,
                               input logic sx, input logic [3:0] sz,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input int gntAt,
                               input int rvAt, input int rvEarly, input int nCycles);
    sel = useTo;
    sIn = st; memRead = ld; memReadSext = sx; iobytes = sz; addr = a; wdataIn = wd;
    if (useTo) startTo = 1'b1;
    else       start   = 1'b1;
    doneCount = 0; doneCycle = -1; reqCount = 0; busyCycles = 0; reqAfterDone = 0;
    stable = 1'b1; doneMis = 1'bx; doneErr = 1'bx; doneBusy = 1'bx; doneReq = 1'bx;
    doneRdata = 32'hx; firstAddr = 32'hx; firstWdata = 32'hx; firstWe = 4'hx;
    @(negedge clk);
    start = 1'b0; startTo = 1'b0;
    addr = ~a; wdataIn = ~wd;
    for (int c = 1; c <= nCycles; c++) begin
      if (oBusy) busyCycles++;
      if (oReq) begin
        reqCount++;
        if (doneCount > 0) reqAfterDone++;
        if (reqCount == 1) begin
          firstAddr = oAddr; firstWe = oWe; firstWdata = oWdata;
        end else if (oAddr !== firstAddr || oWe !== firstWe || oWdata !== firstWdata) begin
          stable = 1'b0;
        end
      end
      if (oDone) begin
        doneCount++;
        if (doneCount == 1) begin
          doneCycle = c; doneMis = oMis; doneErr = oErr; doneBusy = oBusy;
          doneReq = oReq; doneRdata = oRdata;
        end
      end
      dmemGnt    = (c == gntAt);
      dmemRvalid = (c == rvAt) || (c == rvEarly);
      dmemRdata  = (c == rvAt) ? rd : 32'hFFFF_FFFF;
      @(negedge clk);
    end
    dmemGnt = 1'b0; dmemRvalid = 1'b0;
  endtask

  initial begin
    int cnt;
    //             st  ld  sx  sz       a             wd            rd            acc addr          we       wdata         rdata         mis done
    vecs[0]  = '{1'b1,1'b0,1'b0,4'b0001,32'h0000_1002,32'h0000_00AB,32'hFFFF_FFFF,1'b1,32'h0000_1000,4'b0100,32'hABAB_ABAB,32'h0000_0000,1'b0,2};
    vecs[1]  = '{1'b0,1'b1,1'b1,4'b0011,32'h0000_2002,32'h0,        32'h8001_7F00,1'b1,32'h0000_2000,4'b0000,32'h0,        32'hFFFF_8001,1'b0,3};
    vecs[2]  = '{1'b0,1'b1,1'b0,4'b0011,32'h0000_2002,32'h0,        32'h8001_7F00,1'b1,32'h0000_2000,4'b0000,32'h0,        32'h0000_8001,1'b0,3};
    vecs[3]  = '{1'b1,1'b0,1'b0,4'b0011,32'h0000_4002,32'h1234_BEEF,32'hFFFF_FFFF,1'b1,32'h0000_4000,4'b1100,32'hBEEF_BEEF,32'h0000_8001,1'b0,2};
    vecs[4]  = '{1'b1,1'b0,1'b0,4'b1111,32'h0000_5000,32'hDEAD_BEEF,32'hFFFF_FFFF,1'b1,32'h0000_5000,4'b1111,32'hDEAD_BEEF,32'h0000_8001,1'b0,2};
    vecs[5]  = '{1'b0,1'b1,1'b1,4'b0001,32'h0000_6001,32'h0,        32'h1122_8344,1'b1,32'h0000_6000,4'b0000,32'h0,        32'hFFFF_FF83,1'b0,3};
    vecs[6]  = '{1'b0,1'b1,1'b0,4'b0001,32'h0000_6003,32'h0,        32'h9A00_0000,1'b1,32'h0000_6000,4'b0000,32'h0,        32'h0000_009A,1'b0,3};
    vecs[7]  = '{1'b0,1'b1,1'b1,4'b1111,32'h0000_7000,32'h0,        32'hCAFE_F00D,1'b1,32'h0000_7000,4'b0000,32'h0,        32'hCAFE_F00D,1'b0,3};
    vecs[8]  = '{1'b0,1'b1,1'b1,4'b1111,32'h0000_3001,32'h0,        32'h1111_1111,1'b0,32'h0,        4'b0000,32'h0,        32'hCAFE_F00D,1'b1,1};
    vecs[9]  = '{1'b1,1'b0,1'b0,4'b0011,32'h0000_3003,32'h1234_5678,32'hFFFF_FFFF,1'b0,32'h0,        4'b0000,32'h0,        32'hCAFE_F00D,1'b1,1};
    vecs[10] = '{1'b0,1'b0,1'b0,4'b1111,32'h0000_3000,32'h1234_5678,32'h2222_2222,1'b0,32'h0,        4'b0000,32'h0,        32'hCAFE_F00D,1'b0,1};
    vecs[11] = '{1'b1,1'b1,1'b1,4'b0001,32'h0000_8001,32'h0000_005A,32'h3333_3333,1'b1,32'h0000_8000,4'b0010,32'h5A5A_5A5A,32'hCAFE_F00D,1'b0,2};
    vecs[12] = '{1'b0,1'b1,1'b1,4'b0011,32'h0000_A000,32'h0,        32'h1234_7FFF,1'b1,32'h0000_A000,4'b0000,32'h0,        32'h0000_7FFF,1'b0,3};

    sel = 1'b0; reset = 1'b1; start = 1'b0; startTo = 1'b0;
    memRead = 1'b0; memReadSext = 1'b0; sIn = 1'b0; iobytes = 4'd0;
    addr = 32'd0; wdataIn = 32'd0; dmemGnt = 1'b0; dmemRvalid = 1'b0; dmemRdata = 32'd0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst.busy",  mBusy,  0);
    checkOutput("rst.done",  mDone,  0);
    checkOutput("rst.mis",   mMis,   0);
    checkOutput("rst.err",   mErr,   0);
    checkOutput("rst.req",   mReq,   0);
    checkOutput("rst.we",    mWe,    0);
    checkOutput("rst.addr",  mAddr,  0);
    checkOutput("rst.wdata", mWdata, 0);
    checkOutput("rst.rdata", mRdata, 0);
    checkOutput("rst.toReq", tReq,   0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven single accesses against a zero-wait memory
    foreach (vecs[i]) begin
      applyStimulus(1'b0, vecs[i].st, vecs[i].ld, vecs[i].sx, vecs[i].sz, vecs[i].a,
                    vecs[i].wd, vecs[i].rd, 1, 2, 0, vecs[i].expDone + 2);
      checkOutput($sformatf("v%0d.doneCount", i), doneCount, 1);
      checkOutput($sformatf("v%0d.doneCycle", i), doneCycle, vecs[i].expDone);
      checkOutput($sformatf("v%0d.mis", i), doneMis, vecs[i].expMis);
      checkOutput($sformatf("v%0d.err", i), doneErr, 0);
      checkOutput($sformatf("v%0d.busyAtDone", i), doneBusy, 0);
      checkOutput($sformatf("v%0d.rdata", i), doneRdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d.access", i), reqCount != 0, vecs[i].expAccess);
      if (vecs[i].expAccess) begin
        checkOutput($sformatf("v%0d.addr", i), firstAddr, vecs[i].expAddr);
        checkOutput($sformatf("v%0d.we", i), firstWe, vecs[i].expWe);
        checkOutput($sformatf("v%0d.reqAtDone", i), doneReq, 0);
        if (vecs[i].st) checkOutput($sformatf("v%0d.wdata", i), firstWdata, vecs[i].expWdata);
      end
    end

    // Wait states: gnt in cycle 4 (with a stray rvalid that must be ignored),
    // real rvalid in cycle 6, so done lands in cycle 7.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'b1111, 32'h0000_9004, 32'h0,
                  32'h0102_0304, 4, 6, 4, 9);
    checkOutput("ws.reqCycles", reqCount, 4);
    checkOutput("ws.stable", stable, 1);
    checkOutput("ws.addr", firstAddr, 32'h0000_9004);
    checkOutput("ws.busyCycles", busyCycles, 6);
    checkOutput("ws.doneCount", doneCount, 1);
    checkOutput("ws.doneCycle", doneCycle, 7);
    checkOutput("ws.rdata", doneRdata, 32'h0102_0304);

    // MAX_WAIT=4 instance: completion in the last allowed cycle succeeds
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 32'h0000_B000, 32'h1111_1111,
                  32'h0, 4, 0, 0, 6);
    checkOutput("toGnt.doneCycle", doneCycle, 5);
    checkOutput("toGnt.err", doneErr, 0);
    checkOutput("toGnt.reqCycles", reqCount, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_B004, 32'h0,
                  32'h55AA_55AA, 1, 4, 0, 6);
    checkOutput("toRv.doneCycle", doneCycle, 5);
    checkOutput("toRv.err", doneErr, 0);
    checkOutput("toRv.rdata", doneRdata, 32'h55AA_55AA);

    // Gnt never arrives: bus error in cycle 5, rdata kept, req low after
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'b1111, 32'h0000_B008, 32'h0,
                  32'h0, 0, 0, 0, 5);
    checkOutput("to.doneCount", doneCount, 1);
    checkOutput("to.doneCycle", doneCycle, 5);
    checkOutput("to.err", doneErr, 1);
    checkOutput("to.reqCycles", reqCount, 4);
    checkOutput("to.reqAtDone", doneReq, 0);
    checkOutput("to.rdata", doneRdata, 32'h55AA_55AA);
    checkOutput("to.reqAfter", tReq, 0);

    // New start in the cycle right after DONE
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 32'h0000_B00C, 32'h0000_0077,
                  32'h0, 1, 0, 0, 4);
    checkOutput("toNext.doneCycle", doneCycle, 2);
    checkOutput("toNext.err", doneErr, 0);
    checkOutput("toNext.we", firstWe, 4'b0001);

    // Reset while waiting for rvalid, then a late rvalid after release
    sel = 1'b0;
    sIn = 1'b0; memRead = 1'b1; memReadSext = 1'b0; iobytes = 4'b1111; addr = 32'h0000_D000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; dmemGnt = 1'b1;
    @(negedge clk);
    dmemGnt = 1'b0;
    checkOutput("rstMid.busyBefore", oBusy, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("rstMid.busy",  oBusy,  0);
    checkOutput("rstMid.req",   oReq,   0);
    checkOutput("rstMid.we",    oWe,    0);
    checkOutput("rstMid.addr",  oAddr,  0);
    checkOutput("rstMid.wdata", oWdata, 0);
    checkOutput("rstMid.rdata", oRdata, 0);
    @(negedge clk);
    reset = 1'b0; dmemRvalid = 1'b1; dmemRdata = 32'h1234_5678;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (oDone) cnt++;
      if (c == 1) dmemRvalid = 1'b0;
    end
    checkOutput("rstMid.lateDone", cnt, 0);
    checkOutput("rstMid.lateRdata", oRdata, 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 32'h0000_C002, 32'h0,
                  32'h00AB_0000, 1, 2, 0, 5);
    checkOutput("postRst.doneCycle", doneCycle, 3);
    checkOutput("postRst.rdata", doneRdata, 32'h0000_00AB);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
